// File: rtl/serial_word_transmitter.sv
// Parallel-to-serial word transmitter: takes a WIDTH-bit word on valid/ready and emits it MSB first.
// Optional even-parity trailer bit when SERIAL_TX_PARITY_EN is defined.
module serial_word_transmitter #(
  parameter int   WIDTH    = 4,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             out_bit,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int            CW     = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);
  localparam logic [CW-1:0] ONE    = CW'(1);

`ifdef SERIAL_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]    r_bit_cnt;
  logic             r_out_bit;
  logic             r_out_valid;
  logic             r_busy;
  logic             r_done;
`ifdef SERIAL_TX_PARITY_EN
  logic             r_par;
`endif

  logic w_last_bit;
  logic w_accept;

  // The last frame bit is the one currently on out_bit; a new word may be
  // loaded during that cycle so the next frame follows with no gap.
`ifdef SERIAL_TX_PARITY_EN
  assign w_last_bit = (r_state == PARITY);
`else
  assign w_last_bit = (r_state == SHIFT) && (r_bit_cnt == LAST);
`endif

  assign din_ready = rst && ((r_state == IDLE) || w_last_bit);
  assign w_accept  = din_valid && din_ready;

  assign out_bit   = r_out_bit;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign done      = r_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_shreg     <= '0;
      r_bit_cnt   <= '0;
      r_out_bit   <= IDLE_BIT;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      r_par       <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        // MSB goes straight to the output register; shreg holds the remainder.
        r_state     <= SHIFT;
        r_shreg     <= {din[WIDTH-2:0], 1'b0};
        r_bit_cnt   <= '0;
        r_out_bit   <= din[WIDTH-1];
        r_out_valid <= 1'b1;
        r_busy      <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
        r_par       <= ^din;
`endif
      end else begin
        case (r_state)
          SHIFT: begin
            if (r_bit_cnt != LAST) begin
              r_out_bit <= r_shreg[WIDTH-1];
              r_shreg   <= r_shreg << 1;
              r_bit_cnt <= r_bit_cnt + ONE;
`ifndef SERIAL_TX_PARITY_EN
              r_done    <= (r_bit_cnt == PENULT);
`endif
            end else begin
`ifdef SERIAL_TX_PARITY_EN
              r_state   <= PARITY;
              r_out_bit <= r_par;
              r_done    <= 1'b1;
`else
              r_state     <= IDLE;
              r_bit_cnt   <= '0;
              r_out_bit   <= IDLE_BIT;
              r_out_valid <= 1'b0;
              r_busy      <= 1'b0;
`endif
            end
          end
`ifdef SERIAL_TX_PARITY_EN
          PARITY: begin
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_out_bit   <= IDLE_BIT;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
`endif
          default: begin
            r_state     <= IDLE;
            r_out_bit   <= IDLE_BIT;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
